td4_sequencer: RTL and testbench
================================

Name: td4_sequencer

Overview:
- Control and ALU front end of the TD4 core, directly upstream of the A, B and output-port registers.
- Holds the program counter (PC) and the carry flag (C), and presents PC as the instruction ROM address.
- Decodes the 8-bit ROM word, selects an operand, and adds it to the immediate in a 4-bit adder.
- Drives the adder result plus active-low per-register load strobes to the downstream registers.

Parameters:
- RESET_PC, 4'h0, PC value loaded when CLR is asserted.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- CLR  input  1  asynchronous active-low reset.
- EN  input  1  clock enable; 0 freezes PC and C and suppresses all loads.
- ROM_DATA  input  8  instruction word; [7:4] opcode, [3:0] immediate Im.
- A_Q  input  4  current A register value.
- B_Q  input  4  current B register value.
- IN_PORT  input  4  external input port.
- ROM_ADDR  output  4  equals PC.
- ALU_OUT  output  4  adder sum; drives the Im bus of the A, B and OUT registers.
- LOAD_N  output  3  active-low load strobes: [0]=A, [1]=B, [2]=OUT.
- CARRY  output  1  registered carry flag C.

Behaviour:
- Reset: CLR low asynchronously forces PC=RESET_PC and C=0. While CLR is low, LOAD_N=3'b111. After CLR deasserts, the first rising edge fetches address RESET_PC.
- Datapath (combinational): src = SEL mux of {00:A_Q, 01:B_Q, 10:IN_PORT, 11:4'h0}. {cout, ALU_OUT} = src + Im, as a 5-bit sum truncated to a 4-bit result.
- Decode (opcode -> SEL, load target):
  - 0000 ADD A,Im: SEL=00, load A.
  - 0101 ADD B,Im: SEL=01, load B.
  - 0011 MOV A,Im: SEL=11, load A.
  - 0111 MOV B,Im: SEL=11, load B.
  - 0001 MOV A,B: SEL=01, load A.
  - 0100 MOV B,A: SEL=00, load B.
  - 0010 IN A: SEL=10, load A.
  - 0110 IN B: SEL=10, load B.
  - 1001 OUT B: SEL=01, load OUT.
  - 1011 OUT Im: SEL=11, load OUT.
  - 1111 JMP Im: SEL=11, load PC.
  - 1110 JNC Im: SEL=11, load PC only if C==0.
  - All other opcodes are NOP: SEL=11, no load.
- LOAD_N bit for the target is 0 in the same cycle, combinationally from ROM_DATA. At most one LOAD_N bit is low at any time. EN=0 forces LOAD_N=3'b111.
- PC update on each rising edge with EN=1:
  - Jump taken: PC <= ALU_OUT (equals Im, since SEL=11).
  - Otherwise: PC <= PC+1, wrapping 4'hF -> 4'h0.
- C update on each rising edge with EN=1: C <= cout, for every opcode including jumps and NOPs.
  - JNC tests the C produced by the previous instruction.
  - A jump to F with Im+0 never carries, so a jump always clears C.
- EN=0: PC, C and ROM_ADDR hold.
- Reset mid-instruction: CLR takes priority over EN and the jump logic. There is no partial update.
- Latency: one instruction per enabled clock. Downstream registers capture ALU_OUT on the same edge that advances PC.

Decomposition:
- Package td4_pkg holds:
  - opcode localparams (OP_ADD_A ... OP_JNC);
  - SEL encodings (SEL_A, SEL_B, SEL_IN, SEL_ZERO);
  - LOAD_N bit indices (LD_A, LD_B, LD_OUT).
- Sub-module td4_decoder (purely combinational): inputs opcode and C; outputs sel[1:0], load_n[2:0], pc_load.
- The top level holds PC, C, the source mux and the adder.

Test Plan:
- Reset: CLR low with PC previously 4'h7 -> ROM_ADDR=0, CARRY=0, LOAD_N=111, applied immediately without waiting for a clock edge.
- ADD carry: A_Q=4'hC, ROM_DATA=8'h05 -> ALU_OUT=4'h1, LOAD_N=110; after the edge, CARRY=1 and PC=1.
- JNC not taken then taken:
  - C=1, ROM_DATA=8'hE9 -> PC <= PC+1 and C cleared.
  - Next cycle, JNC 9 -> PC=9.
- JMP and wrap:
  - PC=4'hF, ROM_DATA=8'h3A -> PC wraps to 0 and A loads 4'hA.
  - ROM_DATA=8'hF3 -> PC=3, LOAD_N=111.
- EN hold: EN=0 for 3 cycles while executing ADD A,1 -> PC, CARRY unchanged and LOAD_N=111 throughout; resumes correctly when EN=1.
- IN/OUT/NOP:
  - IN_PORT=4'h6 with ROM_DATA=8'h20 -> ALU_OUT=6, LOAD_N=110.
  - 8'h9F with B_Q=2 -> ALU_OUT=1, LOAD_N=011.
  - Opcode 1000 -> LOAD_N=111, PC+1.

Source files
------------

// File: rtl/td4_pkg.sv
// Shared encodings for the TD4 control front end: opcodes, operand selects
// and the bit positions of the active-low load strobes.
package td4_pkg;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_A  = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_B  = 4'b0111;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_IM = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_IN   = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

  localparam int LD_A   = 0;
  localparam int LD_B   = 1;
  localparam int LD_OUT = 2;

endpackage

// File: rtl/td4_decoder.sv
// Combinational opcode decode: operand select, load target and jump request.
// Anything not listed decodes as a NOP (zero operand, no load).
module td4_decoder
  import td4_pkg::*;
(
  input  logic [3:0] i_opcode,
  input  logic       i_carry,
  output logic [1:0] o_sel,
  output logic [2:0] o_load_n,
  output logic       o_pc_load
);

  always_comb begin
    o_sel     = SEL_ZERO;
    o_load_n  = 3'b111;
    o_pc_load = 1'b0;
    case (i_opcode)
      OP_ADD_A:  begin o_sel = SEL_A;    o_load_n[LD_A]   = 1'b0; end
      OP_ADD_B:  begin o_sel = SEL_B;    o_load_n[LD_B]   = 1'b0; end
      OP_MOV_A:  begin o_sel = SEL_ZERO; o_load_n[LD_A]   = 1'b0; end
      OP_MOV_B:  begin o_sel = SEL_ZERO; o_load_n[LD_B]   = 1'b0; end
      OP_MOV_AB: begin o_sel = SEL_B;    o_load_n[LD_A]   = 1'b0; end
      OP_MOV_BA: begin o_sel = SEL_A;    o_load_n[LD_B]   = 1'b0; end
      OP_IN_A:   begin o_sel = SEL_IN;   o_load_n[LD_A]   = 1'b0; end
      OP_IN_B:   begin o_sel = SEL_IN;   o_load_n[LD_B]   = 1'b0; end
      OP_OUT_B:  begin o_sel = SEL_B;    o_load_n[LD_OUT] = 1'b0; end
      OP_OUT_IM: begin o_sel = SEL_ZERO; o_load_n[LD_OUT] = 1'b0; end
      OP_JMP:    begin o_sel = SEL_ZERO; o_pc_load = 1'b1; end
      // JNC looks at the carry left behind by the previous instruction
      OP_JNC:    begin o_sel = SEL_ZERO; o_pc_load = ~i_carry; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/td4_sequencer.sv
// TD4 control and ALU front end: PC, carry flag, operand mux and 4-bit adder,
// producing the sum and active-low load strobes for the A, B and OUT registers.
module td4_sequencer
  import td4_pkg::*;
#(
  parameter logic [3:0] RESET_PC = 4'h0
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       EN,
  input  logic [7:0] ROM_DATA,
  input  logic [3:0] A_Q,
  input  logic [3:0] B_Q,
  input  logic [3:0] IN_PORT,
  output logic [3:0] ROM_ADDR,
  output logic [3:0] ALU_OUT,
  output logic [2:0] LOAD_N,
  output logic       CARRY
);

  logic [3:0] r_pc;
  logic       r_c;

  logic [3:0] w_opcode;
  logic [3:0] w_im;
  logic [1:0] w_sel;
  logic [2:0] w_load_n;
  logic       w_pc_load;
  logic [3:0] w_src;
  logic [4:0] w_sum;

  assign w_opcode = ROM_DATA[7:4];
  assign w_im     = ROM_DATA[3:0];

  td4_decoder u_decoder (
    .i_opcode  (w_opcode),
    .i_carry   (r_c),
    .o_sel     (w_sel),
    .o_load_n  (w_load_n),
    .o_pc_load (w_pc_load)
  );

  always_comb begin
    w_src = 4'h0;
    case (w_sel)
      SEL_A:   w_src = A_Q;
      SEL_B:   w_src = B_Q;
      SEL_IN:  w_src = IN_PORT;
      default: w_src = 4'h0;
    endcase
  end

  assign w_sum = {1'b0, w_src} + {1'b0, w_im};

  // Strobes are gated by CLR as well so downstream registers never load during reset.
  assign LOAD_N   = (EN && CLR) ? w_load_n : 3'b111;
  assign ALU_OUT  = w_sum[3:0];
  assign ROM_ADDR = r_pc;
  assign CARRY    = r_c;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_pc <= RESET_PC;
      r_c  <= 1'b0;
    end else if (EN) begin
      r_pc <= w_pc_load ? w_sum[3:0] : r_pc + 4'd1;
      r_c  <= w_sum[4];
    end
  end

endmodule

// File: tb/tb_td4_sequencer.sv
// Directed bench for td4_sequencer: hand-computed vectors covering reset,
// carry, conditional/unconditional jumps, PC wrap, enable hold and I/O opcodes.
module tb_td4_sequencer;

  logic       CLK;
  logic       CLR;
  logic       EN;
  logic [7:0] ROM_DATA;
  logic [3:0] A_Q;
  logic [3:0] B_Q;
  logic [3:0] IN_PORT;
  logic [3:0] ROM_ADDR;
  logic [3:0] ALU_OUT;
  logic [2:0] LOAD_N;
  logic       CARRY;

  int checks;
  int errors;

  td4_sequencer #(.RESET_PC(4'h0)) dut (
    .CLK      (CLK),
    .CLR      (CLR),
    .EN       (EN),
    .ROM_DATA (ROM_DATA),
    .A_Q      (A_Q),
    .B_Q      (B_Q),
    .IN_PORT  (IN_PORT),
    .ROM_ADDR (ROM_ADDR),
    .ALU_OUT  (ALU_OUT),
    .LOAD_N   (LOAD_N),
    .CARRY    (CARRY)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one enabled clock edge, then settle away from the edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [7:0] rom, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] inp);
    ROM_DATA = rom;
    A_Q      = a;
    B_Q      = b;
    IN_PORT  = inp;
    #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    CLR      = 1'b0;
    EN       = 1'b1;
    ROM_DATA = 8'h00;
    A_Q      = 4'h0;
    B_Q      = 4'h0;
    IN_PORT  = 4'h0;
    tick();
    tick();
    check("rst_addr",  {4'h0, ROM_ADDR}, 8'h00);
    check("rst_carry", {7'h0, CARRY},    8'h00);
    check("rst_load",  {5'h0, LOAD_N},   8'h07);

    CLR = 1'b1;
    drive(8'h80, 4'h0, 4'h0, 4'h0);
    repeat (6) tick();
    check("nop_pc6", {4'h0, ROM_ADDR}, 8'h06);

    // ADD A,5 with A=C: 0xC+5 = 0x11
    drive(8'h05, 4'hC, 4'h0, 4'h0);
    check("add_alu",  {4'h0, ALU_OUT}, 8'h01);
    check("add_load", {5'h0, LOAD_N},  8'h06);
    tick();
    check("add_carry", {7'h0, CARRY},    8'h01);
    check("add_pc",    {4'h0, ROM_ADDR}, 8'h07);

    // asynchronous reset mid-cycle, no clock edge needed
    ROM_DATA = 8'h00;
    #2;
    CLR = 1'b0;
    #1;
    check("async_addr",  {4'h0, ROM_ADDR}, 8'h00);
    check("async_carry", {7'h0, CARRY},    8'h00);
    check("async_load",  {5'h0, LOAD_N},   8'h07);
    @(negedge CLK);
    CLR = 1'b1;
    #1;

    // set C with ADD A,1 where A=F
    drive(8'h01, 4'hF, 4'h0, 4'h0);
    tick();
    check("c_set_carry", {7'h0, CARRY},    8'h01);
    check("c_set_pc",    {4'h0, ROM_ADDR}, 8'h01);

    // JNC 9 with C=1: not taken
    drive(8'hE9, 4'h0, 4'h0, 4'h0);
    check("jnc_nt_alu",  {4'h0, ALU_OUT}, 8'h09);
    check("jnc_nt_load", {5'h0, LOAD_N},  8'h07);
    tick();
    check("jnc_nt_pc",    {4'h0, ROM_ADDR}, 8'h02);
    check("jnc_nt_carry", {7'h0, CARRY},    8'h00);

    // JNC 9 with C=0: taken
    tick();
    check("jnc_t_pc", {4'h0, ROM_ADDR}, 8'h09);

    // JMP F, then MOV A,A from PC=F wraps to 0
    drive(8'hFF, 4'h0, 4'h0, 4'h0);
    tick();
    check("jmp_f_pc", {4'h0, ROM_ADDR}, 8'h0F);
    drive(8'h3A, 4'h5, 4'h0, 4'h0);
    check("mov_a_alu",  {4'h0, ALU_OUT}, 8'h0A);
    check("mov_a_load", {5'h0, LOAD_N},  8'h06);
    tick();
    check("wrap_pc", {4'h0, ROM_ADDR}, 8'h00);

    drive(8'hF3, 4'h0, 4'h0, 4'h0);
    check("jmp3_load", {5'h0, LOAD_N}, 8'h07);
    tick();
    check("jmp3_pc", {4'h0, ROM_ADDR}, 8'h03);

    // set C, then hold with EN=0 for three edges
    drive(8'h01, 4'hF, 4'h0, 4'h0);
    tick();
    check("pre_hold_carry", {7'h0, CARRY},    8'h01);
    check("pre_hold_pc",    {4'h0, ROM_ADDR}, 8'h04);
    EN = 1'b0;
    drive(8'h01, 4'h5, 4'h0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      check("hold_load", {5'h0, LOAD_N}, 8'h07);
      tick();
      check("hold_pc",    {4'h0, ROM_ADDR}, 8'h04);
      check("hold_carry", {7'h0, CARRY},    8'h01);
    end
    EN = 1'b1;
    #1;
    check("resume_alu",  {4'h0, ALU_OUT}, 8'h06);
    check("resume_load", {5'h0, LOAD_N},  8'h06);
    tick();
    check("resume_pc",    {4'h0, ROM_ADDR}, 8'h05);
    check("resume_carry", {7'h0, CARRY},    8'h00);

    // IN A with IN_PORT=6
    drive(8'h20, 4'h0, 4'h0, 4'h6);
    check("in_a_alu",  {4'h0, ALU_OUT}, 8'h06);
    check("in_a_load", {5'h0, LOAD_N},  8'h06);
    tick();
    check("in_a_pc", {4'h0, ROM_ADDR}, 8'h06);

    // OUT B with Im=F, B=2: 2+F = 0x11
    drive(8'h9F, 4'h0, 4'h2, 4'h0);
    check("out_b_alu",  {4'h0, ALU_OUT}, 8'h01);
    check("out_b_load", {5'h0, LOAD_N},  8'h03);
    tick();
    check("out_b_pc",    {4'h0, ROM_ADDR}, 8'h07);
    check("out_b_carry", {7'h0, CARRY},    8'h01);

    // undefined opcode 1000 is a NOP
    drive(8'h85, 4'h0, 4'h0, 4'h0);
    check("nop_alu",  {4'h0, ALU_OUT}, 8'h05);
    check("nop_load", {5'h0, LOAD_N},  8'h07);
    tick();
    check("nop_pc",    {4'h0, ROM_ADDR}, 8'h08);
    check("nop_carry", {7'h0, CARRY},    8'h00);

    // remaining move / output forms
    drive(8'h43, 4'h4, 4'h0, 4'h0);
    check("mov_ba_alu",  {4'h0, ALU_OUT}, 8'h07);
    check("mov_ba_load", {5'h0, LOAD_N},  8'h05);
    drive(8'h10, 4'h0, 4'h9, 4'h0);
    check("mov_ab_alu",  {4'h0, ALU_OUT}, 8'h09);
    check("mov_ab_load", {5'h0, LOAD_N},  8'h06);
    drive(8'hB7, 4'h0, 4'h0, 4'h0);
    check("out_im_alu",  {4'h0, ALU_OUT}, 8'h07);
    check("out_im_load", {5'h0, LOAD_N},  8'h03);
    drive(8'h6C, 4'h0, 4'h0, 4'h2);
    check("in_b_alu",  {4'h0, ALU_OUT}, 8'h0E);
    check("in_b_load", {5'h0, LOAD_N},  8'h05);
    drive(8'h7D, 4'hF, 4'hF, 4'hF);
    check("mov_b_alu",  {4'h0, ALU_OUT}, 8'h0D);
    check("mov_b_load", {5'h0, LOAD_N},  8'h05);
    drive(8'h5E, 4'h0, 4'h3, 4'h0);
    check("add_b_alu",  {4'h0, ALU_OUT}, 8'h01);
    check("add_b_load", {5'h0, LOAD_N},  8'h05);
    tick();
    check("add_b_carry", {7'h0, CARRY},    8'h01);
    check("add_b_pc",    {4'h0, ROM_ADDR}, 8'h09);

    // JMP always clears C
    drive(8'hF2, 4'h0, 4'h0, 4'h0);
    tick();
    check("jmp_clr_carry", {7'h0, CARRY},    8'h00);
    check("jmp_clr_pc",    {4'h0, ROM_ADDR}, 8'h02);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
